// File: rtl/camera_frame_gate.sv
// Frame-level capture gate for the camera pixel packer: vsync-aligned enable, line/frame counting, geometry checks.
// Optional per-line width check is built only when CAM_WIDTH_CHECK_EN is defined.
module camera_frame_gate #(
   parameter int unsigned image_width  = 512,
   parameter int unsigned image_height = 512
) (
   input  logic       pclk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       href,
   input  logic [7:0] datar,
   input  logic [7:0] datag,
   input  logic [7:0] datab,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] frames,
   output logic       en_wr,
   output logic       href_o,
   output logic [7:0] datar_o,
   output logic [7:0] datag_o,
   output logic [7:0] datab_o,
   output logic       busy,
   output logic       done,
   output logic [7:0] frame_cnt,
   output logic [9:0] line_cnt,
   output logic       err_height,
   output logic       err_width
);

   localparam int unsigned FRAME_W = 8;
   localparam int unsigned LINE_W  = 10;
   localparam int unsigned PIX_W   = 13;

   // Geometry must fit the counters it is compared against
   if (image_width == 0 || image_width > 8191 || image_height > 1023) begin : g_bad_geometry
      $error("camera_frame_gate: image geometry does not fit counter widths");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_vsync_d;
   logic                r_href_d;
   logic                w_vs_rise;
   logic                w_hs_rise;
   logic                w_start_c;
   logic                w_frame_end_c;
   logic                w_last_frame_c;
   logic [FRAME_W-1:0]  r_frames;
   logic [FRAME_W-1:0]  r_frame_cnt;
   logic [FRAME_W-1:0]  w_frame_cnt_inc;
   logic [LINE_W-1:0]   r_line_cnt;
   logic                r_en_wr;
   logic                r_busy;
   logic                r_done;
   logic                r_err_height;
   logic                r_href_o;
   logic [7:0]          r_datar_o;
   logic [7:0]          r_datag_o;
   logic [7:0]          r_datab_o;

   assign w_vs_rise       = vsync & ~r_vsync_d;
   assign w_hs_rise       = href & ~r_href_d;
   assign w_frame_cnt_inc = r_frame_cnt + FRAME_W'(1);
   assign w_start_c       = (r_state == S_IDLE) & start & ~abort;
   assign w_frame_end_c   = (r_state == S_CAPTURE) & w_vs_rise & ~abort;
   assign w_last_frame_c  = w_frame_end_c & (r_frames != '0) & (w_frame_cnt_inc == r_frames);

   // Next state; abort overrides everything, including a coincident start
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (start)          w_state_nxt = S_ARM;
            S_ARM:     if (w_vs_rise)      w_state_nxt = S_CAPTURE;
            S_CAPTURE: if (w_last_frame_c) w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_vsync_d    <= 1'b0;
         r_href_d     <= 1'b0;
         r_href_o     <= 1'b0;
         r_datar_o    <= '0;
         r_datag_o    <= '0;
         r_datab_o    <= '0;
         r_en_wr      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_frames     <= '0;
         r_frame_cnt  <= '0;
         r_line_cnt   <= '0;
         r_err_height <= 1'b0;
      end else begin
         r_vsync_d <= vsync;
         r_href_d  <= href;
         r_href_o  <= href;
         r_datar_o <= datar;
         r_datag_o <= datag;
         r_datab_o <= datab;

         r_state <= w_state_nxt;
         r_en_wr <= (w_state_nxt == S_CAPTURE);
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_last_frame_c;

         // Counters and flags freeze on abort so software can inspect where capture stopped
         if (w_start_c) begin
            r_frames     <= frames;
            r_frame_cnt  <= '0;
            r_line_cnt   <= '0;
            r_err_height <= 1'b0;
         end else if (!abort) begin
            case (r_state)
               S_ARM: begin
                  if (w_vs_rise) r_line_cnt <= '0;
               end
               S_CAPTURE: begin
                  if (w_vs_rise) begin
                     if (r_line_cnt != LINE_W'(image_height)) r_err_height <= 1'b1;
                     r_frame_cnt <= w_frame_cnt_inc;
                     r_line_cnt  <= '0;
                  end else if (w_hs_rise && (r_line_cnt != '1)) begin
                     r_line_cnt <= r_line_cnt + LINE_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CAM_WIDTH_CHECK_EN
   logic               w_hs_fall;
   logic [PIX_W-1:0]   r_pix_cnt;
   logic               r_err_width;

   assign w_hs_fall = ~href & r_href_d;

   // Pixel count restarts at 1 on the first href-high cycle of each line
   always_ff @(posedge pclk) begin
      if (reset) begin
         r_pix_cnt   <= '0;
         r_err_width <= 1'b0;
      end else begin
         if (w_hs_rise) begin
            r_pix_cnt <= PIX_W'(1);
         end else if (href && (r_pix_cnt != '1)) begin
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
         end

         if (w_start_c) begin
            r_err_width <= 1'b0;
         end else if (!abort && (r_state == S_CAPTURE) && w_hs_fall &&
                      (r_pix_cnt != PIX_W'(image_width))) begin
            r_err_width <= 1'b1;
         end
      end
   end

   assign err_width = r_err_width;
`else
   assign err_width = 1'b0;
`endif

   assign en_wr      = r_en_wr;
   assign busy       = r_busy;
   assign done       = r_done;
   assign href_o     = r_href_o;
   assign datar_o    = r_datar_o;
   assign datag_o    = r_datag_o;
   assign datab_o    = r_datab_o;
   assign frame_cnt  = r_frame_cnt;
   assign line_cnt   = r_line_cnt;
   assign err_height = r_err_height;

endmodule

// File: tb/tb_camera_frame_gate.sv
// Self-checking bench for camera_frame_gate: randomized camera timing against a frame-level reference model.
module tb_camera_frame_gate;

   localparam int unsigned W = 8;
   localparam int unsigned H = 6;

   logic       pclk = 1'b0;
   logic       reset, vsync, href, start, abort;
   logic [7:0] datar, datag, datab, frames;
   logic       en_wr, href_o, busy, done, err_height, err_width;
   logic [7:0] datar_o, datag_o, datab_o, frame_cnt;
   logic [9:0] line_cnt;

   camera_frame_gate #(.image_width(W), .image_height(H)) dut (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href),
      .datar(datar), .datag(datag), .datab(datab),
      .start(start), .abort(abort), .frames(frames),
      .en_wr(en_wr), .href_o(href_o),
      .datar_o(datar_o), .datag_o(datag_o), .datab_o(datab_o),
      .busy(busy), .done(done), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
      .err_height(err_height), .err_width(err_width)
   );

   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;

`ifdef CAM_WIDTH_CHECK_EN
   localparam bit WCHK = 1'b1;
`else
   localparam bit WCHK = 1'b0;
`endif

   // Reference model: capture described as "waiting for vsync" / "capturing" plus frames remaining
   bit          m_waiting, m_capturing;
   int          m_left, m_frames, m_lines, m_pix;
   bit          m_errh, m_errw, m_pv, m_ph;
   bit          e_done, e_href;
   logic [23:0] e_rgb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit vsr, hsr, hsf;
      if (reset) begin
         m_waiting = 0; m_capturing = 0; m_left = 0; m_frames = 0; m_lines = 0;
         m_pix = 0; m_errh = 0; m_errw = 0; m_pv = 0; m_ph = 0;
         e_done = 0; e_href = 0; e_rgb = '0;
         return;
      end
      vsr = vsync && !m_pv;
      hsr = href && !m_ph;
      hsf = !href && m_ph;
      e_done = 0;
      if (WCHK && hsf && m_capturing && !abort && m_pix != int'(W)) m_errw = 1;
      if (hsr) m_pix = 1;
      else if (href) m_pix++;
      if (abort) begin
         m_waiting = 0;
         m_capturing = 0;
      end else if (!m_waiting && !m_capturing) begin
         if (start) begin
            m_left = (frames == 0) ? -1 : int'(frames);
            m_frames = 0; m_lines = 0; m_errh = 0; m_errw = 0;
            m_waiting = 1;
         end
      end else if (m_waiting) begin
         if (vsr) begin
            m_waiting = 0; m_capturing = 1; m_lines = 0;
         end
      end else if (vsr) begin
         if (m_lines != int'(H)) m_errh = 1;
         m_frames = (m_frames + 1) % 256;
         m_lines = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_capturing = 0;
               e_done = 1;
            end
         end
      end else if (hsr && m_lines < 1023) begin
         m_lines++;
      end
      m_pv = vsync;
      m_ph = href;
      e_href = href;
      e_rgb = {datar, datag, datab};
   endtask

   task automatic tick();
      datar = 8'($urandom); datag = 8'($urandom); datab = 8'($urandom);
      model_step();
      @(posedge pclk);
      #1;
      chk("en_wr", 32'(en_wr), 32'(m_capturing));
      chk("busy", 32'(busy), 32'(m_waiting | m_capturing));
      chk("done", 32'(done), 32'(e_done));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      chk("line_cnt", 32'(line_cnt), 32'(m_lines));
      chk("err_height", 32'(err_height), 32'(m_errh));
      chk("err_width", 32'(err_width), 32'(m_errw));
      chk("href_o", 32'(href_o), 32'(e_href));
      chk("rgb_o", 32'({datar_o, datag_o, datab_o}), 32'(e_rgb));
      if (done === 1'b1) n_done++;
   endtask

   task automatic start_pulse(input int f);
      frames = 8'(f);
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic vs_pulse();
      vsync = 1;
      tick();
      tick();
      vsync = 0;
      repeat ($urandom_range(2, 3)) tick();
   endtask

   // Lines of W pixels; short_idx gets W-2 pixels; abort_idx aborts mid-line and returns with href high
   task automatic gen_lines(input int n, input int short_idx, input int abort_idx);
      for (int l = 1; l <= n; l++) begin
         int w;
         w = (l == short_idx) ? int'(W) - 2 : int'(W);
         href = 1;
         for (int p = 0; p < w; p++) begin
            if (l == abort_idx && p == w / 2) begin
               abort = 1;
               tick();
               abort = 0;
               return;
            end
            tick();
         end
         href = 0;
         repeat ($urandom_range(1, 3)) tick();
      end
   endtask

   initial begin
      int d0;
      reset = 1; vsync = 0; href = 0; start = 0; abort = 0; frames = 0;
      datar = 0; datag = 0; datab = 0;
      repeat (3) tick();
      chk("reset_en_wr", 32'(en_wr), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      reset = 0;
      repeat (2) tick();

      // Single frame
      d0 = n_done;
      start_pulse(1);
      vs_pulse();
      gen_lines(H, 0, 0);
      vs_pulse();
      chk("single_done_count", 32'(n_done - d0), 32'd1);
      chk("single_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("single_err_h", 32'(err_height), 32'd0);
      chk("single_err_w", 32'(err_width), 32'd0);

      // Three frames requested over four camera frames
      d0 = n_done;
      start_pulse(3);
      for (int f = 0; f < 4; f++) begin
         vs_pulse();
         gen_lines(H, 0, 0);
      end
      chk("multi_done_count", 32'(n_done - d0), 32'd1);
      chk("multi_frame_cnt", 32'(frame_cnt), 32'd3);
      chk("multi_busy_after", 32'(busy), 32'd0);

      // Continuous capture aborted during line 100
      d0 = n_done;
      start_pulse(0);
      vs_pulse();
      gen_lines(101, 0, 100);
      chk("abort_en_wr", 32'(en_wr), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_line_cnt", 32'(line_cnt), 32'd100);
      href = 0;
      repeat (3) tick();
      chk("abort_no_done", 32'(n_done - d0), 32'd0);

      // Geometry errors: H-1 lines, line 2 two pixels short
      start_pulse(1);
      vs_pulse();
      gen_lines(H - 1, 2, 0);
      chk("geom_err_w", 32'(err_width), 32'(WCHK));
      chk("geom_err_h_before", 32'(err_height), 32'd0);
      vsync = 1;
      tick();
      chk("geom_err_h", 32'(err_height), 32'd1);
      tick();
      vsync = 0;
      repeat (3) tick();

      // start coincident with vsync rise is not the capture vsync
      d0 = n_done;
      frames = 8'd1;
      start = 1;
      vsync = 1;
      tick();
      start = 0;
      chk("coinc_en_wr", 32'(en_wr), 32'd0);
      chk("coinc_busy", 32'(busy), 32'd1);
      tick();
      vsync = 0;
      repeat (3) tick();
      chk("coinc_still_armed", 32'(en_wr), 32'd0);
      vs_pulse();
      gen_lines(H, 0, 0);
      vs_pulse();
      chk("coinc_done_count", 32'(n_done - d0), 32'd1);

      // start and abort together
      start = 1;
      abort = 1;
      frames = 8'd2;
      tick();
      start = 0;
      abort = 0;
      chk("start_abort_busy", 32'(busy), 32'd0);
      tick();

      // Reset while capturing
      start_pulse(0);
      vs_pulse();
      gen_lines(2, 0, 0);
      href = 1;
      repeat (2) tick();
      reset = 1;
      tick();
      chk("rst_en_wr", 32'(en_wr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_href_o", 32'(href_o), 32'd0);
      chk("rst_line_cnt", 32'(line_cnt), 32'd0);
      chk("rst_rgb_o", 32'({datar_o, datag_o, datab_o}), 32'd0);
      reset = 0;
      href = 0;
      repeat (2) tick();

      // Randomized captures with varying geometry
      for (int r = 0; r < 6; r++) begin
         int f, nfr;
         f = int'($urandom_range(0, 3));
         nfr = (f == 0) ? 2 : f;
         d0 = n_done;
         start_pulse(f);
         repeat ($urandom_range(0, 4)) tick();
         for (int k = 0; k < nfr; k++) begin
            vs_pulse();
            gen_lines(int'(H) - 1 + int'($urandom_range(0, 2)), int'($urandom_range(0, 5)), 0);
         end
         if (f == 0) begin
            abort = 1;
            tick();
            abort = 0;
         end else begin
            vs_pulse();
         end
         chk("rand_done_count", 32'(n_done - d0), (f == 0) ? 32'd0 : 32'd1);
         repeat (2) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
